// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer control path: FSM state
// encodings, lane-select width and default widths for counts and addresses.
package fc_pkg;

    localparam int unsigned SEL_W      = 4;
    localparam int unsigned CNT_W_DEF  = 16;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned TILE_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_FIN     = 3'd5
    } state_t;

endpackage

// File: rtl/fc_tile_scheduler_if.sv
// Datapath-side bundle of the tile scheduler: loader, MAC array and output
// buffer handshakes. The scheduler is the master, the datapath the slave.
interface fc_tile_scheduler_if
    import fc_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);
    logic              load_req;
    logic              load_ack;
    logic [CNT_W-1:0]  in_tile_idx;
    logic [CNT_W-1:0]  out_tile_idx;
    logic              mac_start;
    logic              acc_clear;
    logic              mac_done;
    logic [SEL_W-1:0]  sel_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output load_req, in_tile_idx, out_tile_idx, mac_start, acc_clear,
               sel_data, wr_valid, wr_addr,
        input  load_ack, mac_done, wr_ready
    );

    modport slave (
        input  load_req, in_tile_idx, out_tile_idx, mac_start, acc_clear,
               sel_data, wr_valid, wr_addr,
        output load_ack, mac_done, wr_ready
    );
endinterface

// File: rtl/fc_tile_counter.sv
// Tile index counter with a latched terminal value; is_last is registered so
// the scheduler can branch on it without a wide compare in its own path.
module fc_tile_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_limit,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_is_last
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last_val;
    logic             r_is_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_last_nxt;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_last_nxt = r_last_val;
        if (i_load) begin
            w_cnt_nxt  = '0;
            w_last_nxt = i_limit - CNT_W'(1);
        end else if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_last_val <= '0;
            r_is_last  <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_last_val <= w_last_nxt;
            r_is_last  <= (w_cnt_nxt == w_last_nxt);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_is_last = r_is_last;
endmodule

// File: rtl/fc_tile_scheduler.sv
// Fully-connected layer sequencer: walks the (out_tile, in_tile) grid, drives
// tile loads and MAC runs, then drains TILING_SIZE results per output tile.
module fc_tile_scheduler
    import fc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TILING_SIZE = TILE_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_in_tiles,
    input  logic [CNT_W-1:0]  i_num_out_tiles,
    input  logic [ADDR_W-1:0] i_out_base_addr,
    output logic              o_busy,
    output logic              o_done,
    fc_tile_scheduler_if.master bus
);
    if (TILING_SIZE < 2 || TILING_SIZE > 16 || DATA_WIDTH == 0) begin : g_param_check
        $error("fc_tile_scheduler: unsupported TILING_SIZE or DATA_WIDTH");
    end

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(TILING_SIZE - 1);

    state_t            r_state;
    logic              r_load_req;
    logic              r_mac_start;
    logic              r_acc_clear;
    logic              r_wr_valid;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_in_last;
    logic              w_out_last;
    logic [CNT_W-1:0]  w_in_idx;
    logic [CNT_W-1:0]  w_out_idx;

    assign w_accept = (r_state == ST_IDLE) && i_start &&
                      (i_num_in_tiles != '0) && (i_num_out_tiles != '0);

    fc_tile_counter #(.CNT_W(CNT_W)) u_in_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_limit   (i_num_in_tiles),
        .i_clr     (r_state == ST_NEXT),
        .i_inc     ((r_state == ST_COMPUTE) && bus.mac_done && !w_in_last),
        .o_cnt     (w_in_idx),
        .o_is_last (w_in_last)
    );

    fc_tile_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept),
        .i_limit   (i_num_out_tiles),
        .i_clr     (1'b0),
        .i_inc     ((r_state == ST_NEXT) && !w_out_last),
        .o_cnt     (w_out_idx),
        .o_is_last (w_out_last)
    );

    // Control FSM; every handshake output is a register updated on transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_load_req  <= 1'b0;
            r_mac_start <= 1'b0;
            r_acc_clear <= 1'b0;
            r_wr_valid  <= 1'b0;
            r_sel       <= '0;
            r_base      <= '0;
            r_wr_addr   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_mac_start <= 1'b0;
            r_acc_clear <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_LOAD;
                        r_load_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_base     <= i_out_base_addr;
                    end else if (i_start) begin
                        r_done <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bus.load_ack) begin
                        r_state     <= ST_COMPUTE;
                        r_load_req  <= 1'b0;
                        r_mac_start <= 1'b1;
                        r_acc_clear <= (w_in_idx == '0);
                    end
                end
                ST_COMPUTE: begin
                    if (bus.mac_done) begin
                        if (w_in_last) begin
                            r_state    <= ST_DRAIN;
                            r_wr_valid <= 1'b1;
                            r_sel      <= '0;
                            r_wr_addr  <= r_base + ADDR_W'(w_out_idx) * ADDR_W'(TILING_SIZE);
                        end else begin
                            r_state    <= ST_LOAD;
                            r_load_req <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.wr_ready) begin
                        if (r_sel == SEL_LAST) begin
                            r_state    <= ST_NEXT;
                            r_wr_valid <= 1'b0;
                        end else begin
                            r_sel     <= r_sel + SEL_W'(1);
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_NEXT: begin
                    if (w_out_last) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_state    <= ST_LOAD;
                        r_load_req <= 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.load_req     = r_load_req;
    assign bus.in_tile_idx  = w_in_idx;
    assign bus.out_tile_idx = w_out_idx;
    assign bus.mac_start    = r_mac_start;
    assign bus.acc_clear    = r_acc_clear;
    assign bus.sel_data     = r_sel;
    assign bus.wr_valid     = r_wr_valid;
    assign bus.wr_addr      = r_wr_addr;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Randomised bench for fc_tile_scheduler: responders for loader, MAC and output
// buffer, with a grid-walk reference model of MAC runs and drained writes.
module tb_fc_tile_scheduler;
    localparam int unsigned TS = 8;
    localparam int unsigned CW = 16;
    localparam int unsigned AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_in;
    logic [CW-1:0] num_out;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;

    fc_tile_scheduler_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();

    fc_tile_scheduler #(
        .DATA_WIDTH(16), .TILING_SIZE(TS), .CNT_W(CW), .ADDR_W(AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (start),
        .i_num_in_tiles  (num_in),
        .i_num_out_tiles (num_out),
        .i_out_base_addr (base_addr),
        .o_busy          (busy),
        .o_done          (done),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    int          ld_dly, mac_dly, wmode, ld_cnt, mac_cnt, wr_phase, n_done;
    bit          stray, ld_wait, mac_wait, prev_hold;
    logic [3:0]  prev_sel;
    logic [AW-1:0] prev_addr;
    logic [63:0] obs_mac[$];
    int          obs_addr[$];
    int          obs_sel[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs_vec();
        return {10'd0, bus.load_req, bus.mac_start, bus.acc_clear, bus.wr_valid,
                bus.sel_data, bus.wr_addr, bus.in_tile_idx, bus.out_tile_idx, busy, done};
    endfunction

    task automatic clear_resp();
        ld_wait = 1'b0; mac_wait = 1'b0; prev_hold = 1'b0; ld_cnt = 0; mac_cnt = 0;
    endtask

    // Loader, MAC array and output-buffer behaviour, plus optional stray inputs.
    task automatic respond();
        start        = 1'b0;
        bus.load_ack = 1'b0;
        bus.mac_done = 1'b0;
        if (!ld_wait && bus.load_req) begin
            ld_wait = 1'b1;
            ld_cnt  = (ld_dly < 0) ? int'($urandom_range(0, 3)) : ld_dly;
        end
        if (ld_wait) begin
            if (ld_cnt == 0) begin bus.load_ack = 1'b1; ld_wait = 1'b0; end
            else ld_cnt--;
        end
        if (!mac_wait && bus.mac_start) begin
            mac_wait = 1'b1;
            mac_cnt  = (mac_dly < 0) ? int'($urandom_range(0, 5)) : mac_dly;
        end
        if (mac_wait) begin
            if (mac_cnt == 0) begin bus.mac_done = 1'b1; mac_wait = 1'b0; end
            else mac_cnt--;
        end
        if (stray && bus.load_req && !mac_wait && ($urandom_range(0, 1) == 1))
            bus.mac_done = 1'b1;
        if (stray && bus.mac_start) begin
            start     = 1'b1;
            num_in    = CW'($urandom_range(1, 6));
            num_out   = CW'($urandom_range(1, 6));
            base_addr = AW'($urandom);
        end
        case (wmode)
            0:       bus.wr_ready = 1'b1;
            1:       bus.wr_ready = ((wr_phase % 3) == 0);
            default: bus.wr_ready = 1'($urandom_range(0, 1));
        endcase
        if (bus.wr_valid) wr_phase++;
    endtask

    task automatic tick();
        @(negedge clk);
        if (bus.mac_start)
            obs_mac.push_back({31'd0, bus.out_tile_idx, bus.in_tile_idx, bus.acc_clear});
        if (bus.acc_clear && !bus.mac_start) chk("acc_clear_alone", 64'd1, 64'd0);
        if (done) n_done++;
        if (prev_hold) begin
            chk("hold_valid", 64'(bus.wr_valid), 64'd1);
            chk("hold_sel", 64'(bus.sel_data), 64'(prev_sel));
            chk("hold_addr", 64'(bus.wr_addr), 64'(prev_addr));
        end
        respond();
        if (bus.wr_valid && bus.wr_ready) begin
            obs_addr.push_back(int'(bus.wr_addr));
            obs_sel.push_back(int'(bus.sel_data));
        end
        prev_hold = bus.wr_valid && !bus.wr_ready;
        prev_sel  = bus.sel_data;
        prev_addr = bus.wr_addr;
    endtask

    task automatic run_layer(input int ni, input int no, input int base, input int ldl,
                             input int mdl, input int wm, input bit st, input int abort_sel);
        bit seen_done = 1'b0;
        bit aborted   = 1'b0;
        int k;
        obs_mac.delete(); obs_addr.delete(); obs_sel.delete();
        n_done = 0; wr_phase = 0;
        ld_dly = ldl; mac_dly = mdl; wmode = wm; stray = st;
        num_in = CW'(ni); num_out = CW'(no); base_addr = AW'(base);
        start = 1'b1;
        tick();
        chk("load_req_rise", 64'(bus.load_req), 64'd1);
        chk("busy_rise", 64'(busy), 64'd1);
        for (int c = 0; c < 4000 && !seen_done && !aborted; c++) begin
            tick();
            if (done && !seen_done) begin
                seen_done = 1'b1;
                chk("busy_at_done", 64'(busy), 64'd0);
            end
            if (abort_sel >= 0 && bus.wr_valid && int'(bus.sel_data) == abort_sel) begin
                rst = 1'b1;
                clear_resp();
                tick();
                chk("rst_mid_drain", outs_vec(), 64'd0);
                rst = 1'b0;
                clear_resp();
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            if (!seen_done) begin
                chk("layer_timeout", 64'd0, 64'd1);
            end else begin
                repeat (6) tick();
                chk("done_pulses", 64'(n_done), 64'd1);
                chk("mac_count", 64'(obs_mac.size()), 64'(ni * no));
                k = 0;
                for (int o = 0; o < no; o++)
                    for (int i = 0; i < ni; i++) begin
                        if (k < obs_mac.size())
                            chk("mac_seq", obs_mac[k], {31'd0, CW'(o), CW'(i), (i == 0)});
                        k++;
                    end
                chk("wr_count", 64'(obs_addr.size()), 64'(no * int'(TS)));
                k = 0;
                for (int o = 0; o < no; o++)
                    for (int s = 0; s < int'(TS); s++) begin
                        if (k < obs_addr.size()) begin
                            chk("wr_addr", 64'(obs_addr[k]), 64'((base + o * int'(TS) + s) % (1 << AW)));
                            chk("wr_sel", 64'(obs_sel[k]), 64'(s));
                        end
                        k++;
                    end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; start = 1'b0; num_in = '0; num_out = '0; base_addr = '0;
        bus.load_ack = 1'b0; bus.mac_done = 1'b0; bus.wr_ready = 1'b0;
        ld_dly = 0; mac_dly = 0; wmode = 0; stray = 1'b0; wr_phase = 0; n_done = 0;
        prev_sel = '0; prev_addr = '0;
        clear_resp();
        repeat (3) tick();
        chk("reset_outputs", outs_vec(), 64'd0);
        rst = 1'b0;
        clear_resp();
        tick();

        run_layer(3, 2, 12'h040, 2, 4, 0, 1'b0, -1);
        run_layer(1, 1, 12'h200, 1, 0, 1, 1'b0, -1);

        num_in = 3; num_out = 0; start = 1'b1;
        tick();
        chk("zero_out_done", 64'(done), 64'd1);
        chk("zero_out_busy", 64'(busy), 64'd0);
        chk("zero_out_load_req", 64'(bus.load_req), 64'd0);
        repeat (3) begin
            tick();
            chk("zero_out_idle", {61'd0, busy, bus.load_req, done}, 64'd0);
        end
        num_in = 0; num_out = 2; start = 1'b1;
        tick();
        chk("zero_in_done", 64'(done), 64'd1);
        tick();
        chk("zero_in_idle", {61'd0, busy, bus.load_req, done}, 64'd0);

        run_layer(2, 1, 12'h300, 1, 1, 0, 1'b0, 3);
        run_layer(2, 2, 12'h310, -1, -1, 2, 1'b0, -1);
        run_layer(2, 2, 12'h080, -1, -1, 2, 1'b1, -1);
        run_layer(1, 1, 12'hFFC, 0, 0, 0, 1'b0, -1);
        for (int r = 0; r < 6; r++)
            run_layer(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 4095)), -1, -1,
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
